cam_stream_gen: RTL and testbench
=================================

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

Interface
REQ-001 Parameter H_ACTIVE, default 320: pixels per line.
REQ-002 Parameter V_ACTIVE, default 240: lines per frame.
REQ-003 Parameter HBLANK, default 16: href-low cycles after each line.
REQ-004 Parameter VSYNC_LEN, default 64: vsync-high cycles per frame.
REQ-005 Parameter VBP / VFP, default 32 / 32: back/front porch cycles, vsync low, href low.
REQ-006 p_clock  in  1: single clock; every register SHALL be updated on its rising edge.
REQ-007 rst  in  1: reset, asynchronous, active-high.
REQ-008 enable  in  1: frame generation request.
REQ-009 pix_in  in  24: pixel in the layout {Cr[23:16], Cb[15:8], Y[7:0]}.
REQ-010 pix_valid / pix_ready  in / out  1: pixel handshake; a transfer occurs when both are high on a clock edge.
REQ-011 vsync, href  out  1: frame and line qualifiers to the camera capture side.
REQ-012 p_data  out  8: byte stream.
REQ-013 frame_start, frame_done, underrun  out  1: single-cycle status pulses.

Function
REQ-014 States SHALL be IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
REQ-015 IDLE->VSYNC when enable=1; otherwise stay in IDLE.
REQ-016 VSYNC lasts VSYNC_LEN cycles, VBACK lasts VBP cycles, and VFRONT lasts VFP cycles.
REQ-017 ACTIVE lasts 3*H_ACTIVE cycles and is followed by HBLANK (HBLANK cycles).
REQ-018 HBLANK->ACTIVE while lines < V_ACTIVE; HBLANK->VFRONT after line V_ACTIVE.
REQ-019 End of VFRONT: ->VSYNC if enable=1, else ->IDLE.
REQ-020 enable SHALL be sampled only in IDLE and on the last VFRONT cycle; deassertion mid-frame SHALL let the frame complete.
REQ-021 Outputs SHALL be registered and reflect the current state:
  - vsync=1 in IDLE and VSYNC, 0 elsewhere.
  - href=1 only in ACTIVE.
  - p_data=0 whenever href=0.
REQ-022 In ACTIVE, each pixel SHALL occupy 3 consecutive cycles with p_data = Y, then Cb, then Cr.
REQ-023 A 1-entry holding register SHALL be used, with pix_ready = !hold_full.
  - A transfer SHALL load the holding register.
  - The holding register SHALL be consumed on the Y cycle of each ACTIVE pixel.
  - A load and a consume in the same cycle SHALL both take effect, with pix_ready computed from the post-consume state.
REQ-024 If the holding register is empty at a pixel's Y cycle, that pixel SHALL emit 0x00,0x00,0x00; underrun SHALL pulse on that Y cycle; timing SHALL be unaffected.
REQ-025 Pixels accepted while not in ACTIVE SHALL be held, not dropped; the holding register SHALL not be cleared at frame boundaries.
REQ-026 frame_start SHALL pulse on the first VSYNC cycle.
REQ-027 frame_done SHALL pulse on the last VFRONT cycle.
REQ-028 Frame length SHALL be VSYNC_LEN+VBP+V_ACTIVE*(3*H_ACTIVE+HBLANK)+VFP cycles exactly.
REQ-029 Pixel, byte and line counters SHALL wrap to 0 at their terminal values with no off-by-one; widths SHALL be clog2 of their maximum.

Reset
REQ-030 Reset asserted SHALL immediately force:
  - state IDLE; vsync=1; href=0; p_data=0x00;
  - pix_ready=1; holding register empty;
  - frame_start, frame_done and underrun low; all counters 0.
REQ-031 Reset mid-frame SHALL abort the frame with no frame_done.
REQ-032 After reset release, the first state change SHALL occur on the first clock edge with enable=1.

Verification
Bench parameters for every scenario: H_ACTIVE=2, V_ACTIVE=2, HBLANK=2, VSYNC_LEN=3, VBP=2, VFP=2, giving a 23-cycle frame.
REQ-033 Reset, enable=0 for 10 cycles -> vsync=1, href=0, p_data=0, no pulses.
REQ-034 enable=1 with pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A always valid ->
  - vsync high for 3 cycles, then low for 20;
  - href high 6, low 2, high 6, low 2;
  - p_data 01,02,03,04,05,06 then 07,08,09,0A,0B,0C;
  - frame_done on cycle 23.
REQ-035 pix_valid=0 throughout with enable=1 -> p_data all 0x00 during href, 4 underrun pulses per frame, frame timing unchanged.
REQ-036 enable dropped during line 1 -> frame completes, frame_done pulses, next state IDLE with vsync=1.
REQ-037 enable held high -> back-to-back frames with frame_start exactly 23 cycles apart, on the cycle after frame_done.
REQ-038 rst asserted mid-line -> href=0 and vsync=1 without waiting for a clock edge; no frame_done; pix_ready=1.

Source files
------------

// File: rtl/cam_stream_if.sv
// Camera stream bus: frame request, pixel handshake, and the camera-side
// qualifiers/byte stream with status pulses.
interface cam_stream_if;
  logic        enable;
  logic [23:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic        vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        frame_start;
  logic        frame_done;
  logic        underrun;

  modport master (
    output enable, pix_in, pix_valid,
    input  pix_ready, vsync, href, p_data, frame_start, frame_done, underrun
  );

  modport slave (
    input  enable, pix_in, pix_valid,
    output pix_ready, vsync, href, p_data, frame_start, frame_done, underrun
  );
endinterface

// File: rtl/cam_stream_gen.sv
// Generates a DVP-style camera frame (vsync/href/p_data) from a stream of
// YCbCr pixels, emitting Y, Cb, Cr on three consecutive cycles per pixel.
module cam_stream_gen #(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int HBLANK    = 16,
  parameter int VSYNC_LEN = 64,
  parameter int VBP       = 32,
  parameter int VFP       = 32
) (
  input  logic         p_clock,
  input  logic         rst,
  cam_stream_if.slave  bus
);

  localparam int TMR_MAX = (VSYNC_LEN > VBP ? VSYNC_LEN : VBP) > (HBLANK > VFP ? HBLANK : VFP)
                         ? (VSYNC_LEN > VBP ? VSYNC_LEN : VBP) : (HBLANK > VFP ? HBLANK : VFP);
  localparam int TW = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int PW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [TW-1:0] VS_LAST = TW'(VSYNC_LEN - 1);
  localparam logic [TW-1:0] VB_LAST = TW'(VBP - 1);
  localparam logic [TW-1:0] HB_LAST = TW'(HBLANK - 1);
  localparam logic [TW-1:0] VF_LAST = TW'(VFP - 1);
  localparam logic [PW-1:0] PX_LAST = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LN_LAST = LW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [1:0]    byte_cnt, byte_nx;
  logic [PW-1:0] pix_cnt, pix_nx;
  logic [LW-1:0] line_cnt, line_nx;

  logic [23:0]   hold;
  logic          hold_full;
  logic [15:0]   cur_crcb;
  logic          vsync_q, href_q, fs_q, fd_q, ur_q;
  logic [7:0]    data_q;

  logic y_cycle, consume, xfer;

  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      byte_cnt <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      byte_cnt <= byte_nx;
      pix_cnt  <= pix_nx;
      line_cnt <= line_nx;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    byte_nx  = byte_cnt;
    pix_nx   = pix_cnt;
    line_nx  = line_cnt;
    unique case (state)
      S_IDLE: if (bus.enable) begin
        state_nx = S_VSYNC;
        timer_nx = '0;
      end
      S_VSYNC: if (timer == VS_LAST) begin
        state_nx = S_VBACK;
        timer_nx = '0;
      end else timer_nx = timer + 1'b1;
      S_VBACK: if (timer == VB_LAST) begin
        state_nx = S_ACTIVE;
        timer_nx = '0;
        byte_nx  = '0;
        pix_nx   = '0;
        line_nx  = '0;
      end else timer_nx = timer + 1'b1;
      S_ACTIVE: if (byte_cnt == 2'd2) begin
        byte_nx = '0;
        if (pix_cnt == PX_LAST) begin
          pix_nx   = '0;
          state_nx = S_HBLANK;
          timer_nx = '0;
        end else pix_nx = pix_cnt + 1'b1;
      end else byte_nx = byte_cnt + 1'b1;
      S_HBLANK: if (timer == HB_LAST) begin
        timer_nx = '0;
        if (line_cnt == LN_LAST) begin
          line_nx  = '0;
          state_nx = S_VFRONT;
        end else begin
          line_nx  = line_cnt + 1'b1;
          state_nx = S_ACTIVE;
        end
      end else timer_nx = timer + 1'b1;
      S_VFRONT: if (timer == VF_LAST) begin
        timer_nx = '0;
        state_nx = bus.enable ? S_VSYNC : S_IDLE;
      end else timer_nx = timer + 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  assign y_cycle = (state_nx == S_ACTIVE) && (byte_nx == 2'd0);
  assign consume = y_cycle && hold_full;
  assign bus.pix_ready = !hold_full || consume;
  assign xfer    = bus.pix_valid && bus.pix_ready;

  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (xfer) begin
      hold      <= bus.pix_in;
      hold_full <= 1'b1;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) begin
      vsync_q  <= 1'b1;
      href_q   <= 1'b0;
      data_q   <= '0;
      cur_crcb <= '0;
      fs_q     <= 1'b0;
      fd_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      vsync_q <= (state_nx == S_IDLE) || (state_nx == S_VSYNC);
      href_q  <= (state_nx == S_ACTIVE);
      fs_q    <= (state_nx == S_VSYNC) && (state != S_VSYNC);
      fd_q    <= (state_nx == S_VFRONT) && (timer_nx == VF_LAST);
      ur_q    <= y_cycle && !hold_full;
      if (y_cycle) begin
        data_q   <= hold_full ? hold[7:0] : 8'h00;
        cur_crcb <= hold_full ? hold[23:8] : 16'h0000;
      end else if (state_nx == S_ACTIVE) begin
        data_q <= (byte_nx == 2'd1) ? cur_crcb[7:0] : cur_crcb[15:8];
      end else begin
        data_q <= 8'h00;
      end
    end
  end

  assign bus.vsync       = vsync_q;
  assign bus.href        = href_q;
  assign bus.p_data      = data_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;
  assign bus.underrun    = ur_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen with a small 23-cycle frame geometry.
module tb_cam_stream_gen;
  localparam int H_ACTIVE = 2, V_ACTIVE = 2, HBLANK = 2, VSYNC_LEN = 3, VBP = 2, VFP = 2;
  localparam int FRAME = 23;

  logic p_clock = 1'b0;
  logic rst     = 1'b0;
  always #5 p_clock = ~p_clock;

  cam_stream_if bus();

  cam_stream_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .HBLANK(HBLANK),
    .VSYNC_LEN(VSYNC_LEN), .VBP(VBP), .VFP(VFP)
  ) dut (
    .p_clock(p_clock),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int pix_idx = 0;
  bit feed_on = 1'b0;

  function automatic logic [23:0] pix_tab(input int i);
    return 24'h030201 + 24'(i) * 24'h030303;
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    logic x;
    @(negedge p_clock);
    x = bus.pix_valid && bus.pix_ready;
    @(posedge p_clock);
    #1;
    if (x && feed_on) begin
      pix_idx++;
      bus.pix_in = pix_tab(pix_idx);
      if (pix_idx == 4) bus.pix_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input bit pix_on, input int drop_at, input string nm);
    bit act;
    int j;
    logic [7:0] exp_d;
    for (int k = 1; k <= FRAME; k++) begin
      if (k == drop_at) bus.enable = 1'b0;
      tick();
      act = (k >= 6 && k <= 11) || (k >= 14 && k <= 19);
      j   = (k <= 11) ? k - 6 : k - 14 + 6;
      exp_d = (act && pix_on) ? 8'(j + 1) : 8'h00;
      chk({nm, " vsync"},       {23'd0, bus.vsync},       {23'd0, k <= 3});
      chk({nm, " href"},        {23'd0, bus.href},        {23'd0, act});
      chk({nm, " p_data"},      {16'd0, bus.p_data},      {16'd0, exp_d});
      chk({nm, " frame_start"}, {23'd0, bus.frame_start}, {23'd0, k == 1});
      chk({nm, " frame_done"},  {23'd0, bus.frame_done},  {23'd0, k == FRAME});
      chk({nm, " underrun"},    {23'd0, bus.underrun},    {23'd0, !pix_on && act && (j % 3 == 0)});
    end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst vsync", {23'd0, bus.vsync}, 24'd1);
    chk("rst href", {23'd0, bus.href}, 24'd0);
    chk("rst p_data", {16'd0, bus.p_data}, 24'd0);
    chk("rst pix_ready", {23'd0, bus.pix_ready}, 24'd1);
    chk("rst pulses", {21'd0, bus.frame_start, bus.frame_done, bus.underrun}, 24'd0);
    repeat (2) @(posedge p_clock);
    @(negedge p_clock) rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle vsync", {23'd0, bus.vsync}, 24'd1);
      chk("idle href/data", {15'd0, bus.href, bus.p_data}, 24'd0);
      chk("idle pulses", {21'd0, bus.frame_start, bus.frame_done, bus.underrun}, 24'd0);
    end

    // Preload the holding register while idle; it must stay full until ACTIVE.
    pix_idx = 0;
    bus.pix_in = pix_tab(0);
    bus.pix_valid = 1'b1;
    feed_on = 1'b1;
    tick();
    chk("preload pix_ready", {23'd0, bus.pix_ready}, 24'd0);
    chk("preload vsync", {23'd0, bus.vsync}, 24'd1);

    bus.enable = 1'b1;
    run_frame(1'b1, 0, "f1");
    run_frame(1'b0, 0, "f2");
    run_frame(1'b0, 8, "f3");
    tick();
    chk("post idle vsync", {23'd0, bus.vsync}, 24'd1);
    chk("post idle fs/href", {22'd0, bus.frame_start, bus.href}, 24'd0);
    tick();
    chk("post idle hold vsync", {23'd0, bus.vsync}, 24'd1);

    // Reset mid-line with a full holding register.
    feed_on = 1'b0;
    bus.pix_in = 24'h112233;
    bus.pix_valid = 1'b1;
    bus.enable = 1'b1;
    repeat (7) tick();
    chk("pre-rst href", {23'd0, bus.href}, 24'd1);
    chk("pre-rst p_data", {16'd0, bus.p_data}, 24'h000022);
    chk("pre-rst pix_ready", {23'd0, bus.pix_ready}, 24'd0);
    #2 rst = 1'b1;
    #1;
    chk("async href", {23'd0, bus.href}, 24'd0);
    chk("async vsync", {23'd0, bus.vsync}, 24'd1);
    chk("async p_data", {16'd0, bus.p_data}, 24'd0);
    chk("async pix_ready", {23'd0, bus.pix_ready}, 24'd1);
    bus.enable = 1'b0;
    bus.pix_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      chk("rst no frame_done", {23'd0, bus.frame_done}, 24'd0);
    end
    @(negedge p_clock) rst = 1'b0;
    repeat (2) begin
      tick();
      chk("after rst vsync", {23'd0, bus.vsync}, 24'd1);
      chk("after rst href", {23'd0, bus.href}, 24'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
